// File: rtl/ram_dma.sv
// Block-copy initiator for a RAM512-style memory port.
// Each word takes two cycles: a READ that latches mem_out, then a WRITE that stores it.
module ram_dma #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_load,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_out
);

    localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W:0]   len_reg;
    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W:0]   count_inc;

    assign count_inc = count + COUNT_ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory-port outputs are pure state decodes, so mem_load cannot glitch outside WRITE
    // and everything falls to zero the instant reset forces IDLE.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_load    = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_reg + count[ADDR_W-1:0];
                state_next  = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_load    = 1'b1;
                mem_address = dst_reg + count[ADDR_W-1:0];
                mem_in      = data_reg;
                state_next  = (count_inc < len_reg) ? READ : DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Copy arguments are captured only on an accepted start, so later start pulses cannot disturb a copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_reg  <= '0;
            dst_reg  <= '0;
            len_reg  <= '0;
            data_reg <= '0;
            count    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_reg <= src;
                        dst_reg <= dst;
                        len_reg <= len;
                        count   <= '0;
                    end
                end
                READ: begin
                    data_reg <= mem_out;
                end
                WRITE: begin
                    count <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Directed testbench for ram_dma, with a behavioural RAM512 attached to its memory port.
module tb_ram_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  src;
    logic [8:0]  dst;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic [9:0]  count;
    logic [8:0]  mem_address;
    logic        mem_load;
    logic [15:0] mem_in;
    logic [15:0] mem_out;

    logic [15:0] ram [0:511];

    int checks = 0;
    int errors = 0;

    ram_dma #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .mem_address (mem_address),
        .mem_load    (mem_load),
        .mem_in      (mem_in),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM512: combinational read, write on the rising edge while load is high.
    assign mem_out = ram[mem_address];
    always @(posedge clk) begin
        if (mem_load) ram[mem_address] <= mem_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int s, input int d, input int n);
        start = 1'b1;
        src   = s[8:0];
        dst   = d[8:0];
        len   = n[9:0];
        tick();
        start = 1'b0;
    endtask

    // Samples one cycle at a time starting just after the accepting edge; optionally
    // throws a competing start at the DUT mid-copy and again while done is high.
    task automatic run_window(input int cycles, input bit disturb,
                              output int busy_n, output int load_n,
                              output int done_n, output int done_at);
        busy_n  = 0;
        load_n  = 0;
        done_n  = 0;
        done_at = -1;
        for (int i = 0; i < cycles; i++) begin
            if (busy) busy_n++;
            if (mem_load) load_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (disturb) begin
                start = (i == 3) || (done_at == i);
                src   = 9'd300;
                dst   = 9'd400;
                len   = 10'd7;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic run_copy(input string name, input int s, input int d, input int n, input bit disturb);
        int b, l, dn, da;
        applyStimulus(s, d, n);
        run_window(2 * n + 5, disturb, b, l, dn, da);
        checkOutput({name, "_busy_cycles"}, b, 2 * n);
        checkOutput({name, "_load_cycles"}, l, n);
        checkOutput({name, "_done_pulses"}, dn, 1);
        checkOutput({name, "_done_at"}, da, 2 * n);
        checkOutput({name, "_count"}, {22'd0, count}, n);
    endtask

    task automatic check_idle_zero(input string name);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_done"}, done, 0);
        checkOutput({name, "_mem_load"}, mem_load, 0);
        checkOutput({name, "_count"}, {22'd0, count}, 0);
        checkOutput({name, "_mem_address"}, {23'd0, mem_address}, 0);
        checkOutput({name, "_mem_in"}, {16'd0, mem_in}, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        #3;
        check_idle_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Basic four-word copy
        ram[10] = 16'hA0A1;
        ram[11] = 16'hB0B1;
        ram[12] = 16'hC0C1;
        ram[13] = 16'hD0D1;
        run_copy("s1", 10, 100, 4, 1'b0);
        checkOutput("s1_ram100", ram[100], 16'hA0A1);
        checkOutput("s1_ram101", ram[101], 16'hB0B1);
        checkOutput("s1_ram102", ram[102], 16'hC0C1);
        checkOutput("s1_ram103", ram[103], 16'hD0D1);
        checkOutput("s1_src10", ram[10], 16'hA0A1);
        checkOutput("s1_src13", ram[13], 16'hD0D1);

        // Zero-length copy
        ram[300] = 16'h5555;
        ram[7]   = 16'h0707;
        run_copy("s2", 7, 300, 0, 1'b0);
        checkOutput("s2_ram300", ram[300], 16'h5555);

        // Source wraps past the top of memory
        ram[510] = 16'h0001;
        ram[511] = 16'h0002;
        ram[0]   = 16'h0003;
        ram[1]   = 16'h0004;
        run_copy("s3", 510, 20, 4, 1'b0);
        checkOutput("s3_ram20", ram[20], 16'h0001);
        checkOutput("s3_ram21", ram[21], 16'h0002);
        checkOutput("s3_ram22", ram[22], 16'h0003);
        checkOutput("s3_ram23", ram[23], 16'h0004);

        // Overlapping ascending copy replicates the first word
        ram[50] = 16'h1234;
        ram[51] = 16'h0011;
        ram[52] = 16'h0022;
        ram[53] = 16'h0033;
        ram[54] = 16'h9999;
        run_copy("s4", 50, 51, 3, 1'b0);
        checkOutput("s4_ram51", ram[51], 16'h1234);
        checkOutput("s4_ram52", ram[52], 16'h1234);
        checkOutput("s4_ram53", ram[53], 16'h1234);
        checkOutput("s4_ram54", ram[54], 16'h9999);

        // Start pulses while busy and in DONE must be ignored
        for (int i = 100; i < 104; i++) ram[i] = 16'h0000;
        for (int i = 400; i < 407; i++) ram[i] = 16'h7777;
        run_copy("s6", 10, 100, 4, 1'b1);
        checkOutput("s6_ram100", ram[100], 16'hA0A1);
        checkOutput("s6_ram103", ram[103], 16'hD0D1);
        checkOutput("s6_ram400", ram[400], 16'h7777);

        // Reset during the third word's WRITE cycle aborts the copy
        for (int i = 200; i < 204; i++) ram[i] = 16'hEEEE;
        applyStimulus(10, 200, 4);
        repeat (5) tick();
        checkOutput("s5_load_before", mem_load, 1);
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("s5_abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("s5_ram200", ram[200], 16'hA0A1);
        checkOutput("s5_ram201", ram[201], 16'hB0B1);
        checkOutput("s5_ram202", ram[202], 16'hEEEE);
        checkOutput("s5_ram203", ram[203], 16'hEEEE);
        tick();
        run_copy("s5_after", 12, 210, 2, 1'b0);
        checkOutput("s5_ram210", ram[210], 16'hC0C1);
        checkOutput("s5_ram211", ram[211], 16'hD0D1);

        // Full-memory copy onto itself exercises the 512-word length
        ram[5] = 16'h0505;
        run_copy("full", 0, 0, 512, 1'b0);
        checkOutput("full_ram5", ram[5], 16'h0505);
        checkOutput("full_ram511", ram[511], 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
